// File: rtl/upstream_hb_arbiter.sv
// upstream_hb_arbiter
//
// Purpose: shares the single upstream output channel between the upstream
// data stream and periodic heartbeat words. A heartbeat fires every
// hb_interval time units and is emitted as two tagged words: the low half
// of the wall time, then the high half, both from one snapshot.
//
// Ports:
//   clk, reset      clock; asynchronous active-high reset
//   unit_pulse      one-cycle pulse per time unit (time manager)
//   time_elapsed    current wall time, 2*Nword bits
//   reset_time      time-reset strobe; clears the interval counter and any
//                   pending heartbeat
//   hb_interval     time units between heartbeats; 0 disables heartbeats
//   in_v/in_a/in_d  upstream data channel (this block is the sink)
//   out_v/out_a/out_d  output channel; out_d = {tag[1:0], payload[Nword-1:0]}
//                   tags: 00 data, 01 heartbeat low, 10 heartbeat high
//   hb_missed       one-cycle pulse when a trigger merges into a heartbeat
//                   that is already pending
//
// Handshake: a word moves on a posedge where valid and ready are both 1.
// Once out_v is high, out_d holds until that transfer. The output register
// reloads whenever it is empty or being drained (load = !out_v | out_a).

module upstream_hb_arbiter #(
    parameter int Nword = 20,
    parameter int Nhb   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 unit_pulse,
    input  logic [2*Nword-1:0]   time_elapsed,
    input  logic                 reset_time,
    input  logic [Nhb-1:0]       hb_interval,
    input  logic                 in_v,
    output logic                 in_a,
    input  logic [Nword-1:0]     in_d,
    output logic                 out_v,
    input  logic                 out_a,
    output logic [Nword+1:0]     out_d,
    output logic                 hb_missed
);

    localparam logic [1:0]     TAG_DATA = 2'b00;
    localparam logic [1:0]     TAG_LO   = 2'b01;
    localparam logic [1:0]     TAG_HI   = 2'b10;
    localparam logic [Nhb-1:0] CNT_ONE  = {{(Nhb-1){1'b0}}, 1'b1};

    logic [Nhb-1:0]     cnt;
    logic               pending;
    logic               hi_owed;
    logic [2*Nword-1:0] snap;

    logic load;
    logic hb_en;
    logic at_wrap;
    logic trigger;
    logic lo_load;

    assign load  = !out_v || out_a;
    assign hb_en = (hb_interval != '0);

    // ">=" rather than "==" so that shrinking hb_interval below the current
    // count fires on the very next pulse instead of running the counter
    // all the way around.
    assign at_wrap = (cnt >= (hb_interval - CNT_ONE));

    // A time reset overrides a same-cycle trigger.
    assign trigger = unit_pulse && hb_en && at_wrap && !reset_time;

    // The heartbeat low word is taken into the output register this cycle.
    assign lo_load = load && !hi_owed && pending;

    // Data is refused while any part of a heartbeat is waiting, which keeps
    // the LO/HI pair adjacent on the output.
    assign in_a = load && !hi_owed && !pending && !reset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt       <= '0;
            pending   <= 1'b0;
            hi_owed   <= 1'b0;
            snap      <= '0;
            out_v     <= 1'b0;
            out_d     <= '0;
            hb_missed <= 1'b0;
        end else begin
            // A trigger landing on an already-pending heartbeat is only
            // reported; the pending flag saturates at one.
            hb_missed <= trigger && pending && !lo_load;

            // Interval counter.
            if (reset_time || !hb_en) begin
                cnt <= '0;
            end else if (unit_pulse) begin
                cnt <= at_wrap ? '0 : cnt + CNT_ONE;
            end

            // Pending flag: a new trigger wins over the LO load that
            // consumes the previous one.
            if (reset_time) begin
                pending <= 1'b0;
            end else if (trigger) begin
                pending <= 1'b1;
            end else if (lo_load) begin
                pending <= 1'b0;
            end

            // Output register source selection. hi_owed and snap survive a
            // time reset so a pair already started is always completed.
            if (load) begin
                if (hi_owed) begin
                    out_v   <= 1'b1;
                    out_d   <= {TAG_HI, snap[2*Nword-1:Nword]};
                    hi_owed <= 1'b0;
                end else if (pending) begin
                    out_v   <= 1'b1;
                    out_d   <= {TAG_LO, time_elapsed[Nword-1:0]};
                    snap    <= time_elapsed;
                    hi_owed <= 1'b1;
                end else if (in_v) begin
                    out_v   <= 1'b1;
                    out_d   <= {TAG_DATA, in_d};
                end else begin
                    out_v   <= 1'b0;
                end
            end
        end
    end

endmodule

// File: doc/upstream_hb_arbiter.md
# upstream_hb_arbiter

Shares the single upstream output channel between the upstream data stream and periodic heartbeat words derived from the wall clock. Heartbeats are scheduled every `hb_interval` time units using the time manager's `unit_pulse` and `time_elapsed`. Each heartbeat is emitted as two tagged words: the low half of time, then the high half. The block sits between the upstream traffic merge and the upstream serializer, directly downstream of the time manager.

## Interface
- `Nword`, 20, payload width; `time_elapsed` is 2*Nword bits wide.
- `Nhb`, 8, width of the heartbeat interval counter.
- `clk`  in  1  clock
- `reset`  in  1  reset, asynchronous, active-high
- `unit_pulse`  in  1  one-cycle pulse per time unit, from the time manager
- `time_elapsed`  in  2*Nword  current wall time; increments on the same edge that follows a `unit_pulse` cycle
- `reset_time`  in  1  time-reset strobe; same signal the time manager sees
- `hb_interval`  in  Nhb  time units between heartbeats; 0 disables heartbeats
- `in_v` / `in_a` / `in_d`  in / out / in  1 / 1 / Nword  upstream data channel
- `out_v` / `out_a` / `out_d`  out / in / out  1 / 1 / Nword+2  output channel; `out_d[Nword+1:Nword]` is the tag, `out_d[Nword-1:0]` is the payload
- `hb_missed`  out  1  one-cycle pulse when a heartbeat trigger merges into an already-pending heartbeat

## Operation
- **Handshake.** A word transfers on a posedge where v=1 and a=1. Once `out_v` is asserted, `out_d` is held stable until the transfer.
- **Tags.**
  - 00: data.
  - 01: heartbeat low word, `time_elapsed[Nword-1:0]`.
  - 10: heartbeat high word, `time_elapsed[2*Nword-1:Nword]`.
  - 11: never emitted.
- **Interval counter `cnt`.**
  - On `unit_pulse` with `hb_interval`≠0: if `cnt`==`hb_interval`-1, then `cnt`←0 and the trigger fires; otherwise `cnt`←`cnt`+1.
  - With `hb_interval`=0, `cnt` is held at 0 and no triggers fire.
  - A runtime change of `hb_interval` takes effect on the next pulse. If `cnt` ≥ new `hb_interval`-1, the next pulse fires and wraps `cnt` to 0.
- **Pending flag.** A trigger sets `pending`. A trigger while `pending`=1 and no HB_LO load is occurring in the same cycle pulses `hb_missed`; `pending` stays 1.
- **Output register.** `load` = !`out_v` | `out_a`. When `load`, the source is chosen in this priority order:
  1. `hi_owed`=1: load tag 10 with `snap[2*Nword-1:Nword]`; clear `hi_owed`.
  2. `pending`=1: load tag 01 with `time_elapsed[Nword-1:0]`; `snap`←`time_elapsed`; clear `pending`; set `hi_owed`.
  3. `in_v`=1: load tag 00 with `in_d`.
  4. Otherwise: `out_v`←0.
- **Data acknowledge.** `in_a` = `load` & !`hi_owed` & !`pending` & !`reset` (combinational). Data is never accepted between the LO and HI words of a heartbeat.
- **Simultaneous trigger and HB_LO load.** `pending` ends at 1 (set wins). That trigger does not count as missed.
- **`reset_time`=1.** Clears `cnt` and `pending` and takes priority over a same-cycle trigger. It does not abort an in-progress LO/HI pair: `hi_owed` and `snap` are kept.
- **Reset values.** `out_v`=0, `out_d`=0, `hb_missed`=0, `in_a`=0; internal `cnt`=0, `pending`=0, `hi_owed`=0, `snap`=0.
- **Reset mid-operation.** Reset mid-heartbeat drops the pair entirely; after reset, no HI word is emitted.

## Timing
- **Heartbeat latency.** `unit_pulse` at cycle t (firing) → `pending`=1 at t+1 → with the output free, `out_v`=1 with tag 01 at t+2.
  - The LO payload is the `time_elapsed` value after its t+1 increment.
  - The HI word is presented on the cycle after the LO transfers.
- **Data latency.** Data passes with 1 cycle of latency.
- **Throughput.** Sustained 1 word/cycle with `out_a` held at 1.
- **Backpressure.** `out_a`=0 stalls everything; the state is held.
- **Starvation bound.** Data is never starved for more than 2 consecutive words per heartbeat.
- **Pending bound.** At most one heartbeat is pending. Extra triggers are counted only via `hb_missed`.

## Test plan
- **Basic cadence.** `hb_interval`=3, `unit_pulse` every 8 clks, `in_v`=0, `out_a`=1 → a LO/HI pair is emitted every 24 clks. LO payload = T[19:0] and HI payload = T[39:20] of one consistent snapshot; a test value T=0x0000100005 gives LO 0x00005, HI 0x00001.
- **Saturated data stream.** `in_v`=1 continuously with an incrementing `in_d`, `hb_interval`=1 → every heartbeat appears as adjacent 01,10 words. Data order and values are preserved, no data word is lost, and `in_a` is 0 on exactly 2 cycles per heartbeat.
- **Backpressure.** `out_a`=0 for 40 clks with `hb_interval`=1 and pulses every 8 clks → `out_d` stays stable while `out_v`=1, and `hb_missed` pulses on each trigger after the first. After `out_a`=1, exactly one pair is emitted, carrying the time at LO load.
- **Time reset.**
  - `reset_time` on the same cycle as a firing pulse → no heartbeat.
  - `reset_time` between the LO and HI transfers → the HI word is still emitted, from `snap`.
- **Disable.** `hb_interval`=0 → no heartbeats over 100 pulses, and data passes at 1 word/cycle. Re-enabling with 2 → first pair emitted 2 pulses later.
- **Reset mid-heartbeat.** Async reset asserted with `out_v`=1 and tag 01 → `out_v`=0 immediately. After release, no tag-10 word appears before the next LO.
